// File: rtl/fft_pingpong_loader.sv
// fft_pingpong_loader
// Two-bank ping-pong frame buffer between the SPI deserializer and the FFT core.
// SPI writes whole frames (real or complex) into alternating banks. The bank
// being read is streamed into the FFT one point per clock, honouring fft_stall.
// A frame that arrives while both banks are occupied is dropped and flagged.
// Frames are delivered strictly in the order they were accepted.

module fft_pingpong_loader #(
    parameter int N_POINTS = 64,
    parameter int SAMPLE_W = 16,
    parameter int IDX_W    = $clog2(N_POINTS),
    parameter int FRAME_W  = 2 * N_POINTS * SAMPLE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_W-1:0]    frame_in,
    input  logic                  frame_valid,
    input  logic                  cplx_mode,
    input  logic                  fft_busy,
    input  logic                  fft_stall,
    output logic [2*SAMPLE_W-1:0] fft_data,
    output logic [IDX_W-1:0]      fft_idx,
    output logic                  fft_load,
    output logic                  fft_start,
    output logic [1:0]            bank_full,
    output logic                  frame_drop,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_START = 2'd2
    } state_t;

    // A frame is viewed as 2*N_POINTS words; word 2*N_POINTS-1 sits at the MSB.
    localparam int WORDS  = 2 * N_POINTS;
    localparam int WSEL_W = IDX_W + 1;

    // Control state
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic             frame_drop_q, frame_drop_d;
    logic             overflow_q, overflow_d;

    // Bank storage
    logic [FRAME_W-1:0] bank_frame_q [2];
    logic [FRAME_W-1:0] bank_frame_d [2];
    logic [1:0]         bank_cplx_q, bank_cplx_d;

    // Derived control
    logic load_fire;
    logic last_point;
    logic release_rd;
    logic wr_bank_free;
    logic accept;

    // Read-side extraction
    logic [WORDS-1:0][SAMPLE_W-1:0] rd_words;
    logic                           rd_cplx;
    logic [WSEL_W-1:0]              real_word;
    logic [WSEL_W-1:0]              cplx_re_word;
    logic [WSEL_W-1:0]              cplx_im_word;

    // Handshake and bank-availability decode for the current cycle
    always_comb begin
        load_fire  = (state_q == ST_LOAD) && !fft_stall;
        last_point = (idx_q == IDX_W'(N_POINTS - 1));
        // The START cycle frees the bank being read, and a write in the same
        // cycle may reuse it immediately.
        release_rd   = (state_q == ST_START);
        wr_bank_free = !bank_full_q[wr_sel_q] || (release_rd && (rd_sel_q == wr_sel_q));
        accept       = frame_valid && wr_bank_free;
    end

    // Write side: bank occupancy, write pointer and drop/overflow flags
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        bank_full_d  = bank_full_q;
        wr_sel_d     = wr_sel_q;
        bank_cplx_d  = bank_cplx_q;
        bank_frame_d = bank_frame_q;
        frame_drop_d = 1'b0;
        overflow_d   = overflow_q;

        if (release_rd) begin
            bank_full_d[rd_sel_q] = 1'b0;
        end

        if (accept) begin
            bank_frame_d[wr_sel_q] = frame_in;
            bank_cplx_d[wr_sel_q]  = cplx_mode;
            bank_full_d[wr_sel_q]  = 1'b1;
            wr_sel_d               = ~wr_sel_q;
        end else if (frame_valid) begin
            // Both banks are held: never overwrite, report the loss instead.
            frame_drop_d = 1'b1;
            overflow_d   = 1'b1;
        end
    end

    // Read-side FSM next state: wait for a full bank, stream it, then pulse start
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rd_sel_d = rd_sel_q;

        case (state_q)
            ST_IDLE: begin
                if (bank_full_q[rd_sel_q] && !fft_busy) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end
            end
            ST_LOAD: begin
                // fft_busy is not consulted here: once a load starts it completes.
                if (load_fire) begin
                    if (last_point) begin
                        // Index is left at the last point so fft_idx holds it.
                        state_d = ST_START;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_START: begin
                rd_sel_d = ~rd_sel_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Point extraction from the bank being read
    always_comb begin
        rd_words = bank_frame_q[rd_sel_q];
        rd_cplx  = bank_cplx_q[rd_sel_q];

        // Real frames use one word per point from the upper half; complex
        // frames use two adjacent words per point, re above im.
        real_word    = WSEL_W'(WORDS - 1) - {1'b0, idx_q};
        cplx_re_word = WSEL_W'(WORDS - 1) - {idx_q, 1'b0};
        cplx_im_word = cplx_re_word - WSEL_W'(1);

        if (rd_cplx) begin
            fft_data = {rd_words[cplx_re_word], rd_words[cplx_im_word]};
        end else begin
            fft_data = {rd_words[real_word], {SAMPLE_W{1'b0}}};
        end
    end

    // Control registers with synchronous reset; reset aborts any load and empties both banks
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            bank_full_q  <= 2'b00;
            bank_cplx_q  <= 2'b00;
            frame_drop_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            bank_full_q  <= bank_full_d;
            bank_cplx_q  <= bank_cplx_d;
            frame_drop_q <= frame_drop_d;
            overflow_q   <= overflow_d;
        end
    end

    // Frame storage for both banks
    always_ff @(posedge clk) begin
        // NOTE: frame storage is not reset; bank_full_q gates every read, so stale contents are never used.
        bank_frame_q <= bank_frame_d;
    end

    // Output mapping
    assign fft_load   = load_fire;
    assign fft_idx    = idx_q;
    assign fft_start  = (state_q == ST_START);
    assign bank_full  = bank_full_q;
    assign frame_drop = frame_drop_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_pingpong_loader.sv
// Directed testbench for fft_pingpong_loader (N_POINTS=64, SAMPLE_W=16).
// Inputs change 1 ns after the rising edge; outputs are compared 1 ns later,
// well clear of the next edge.

module tb_fft_pingpong_loader;

    localparam int N  = 64;
    localparam int SW = 16;
    localparam int IW = 6;
    localparam int FW = 2 * N * SW;

    logic          clk;
    logic          reset;
    logic [FW-1:0] frame_in;
    logic          frame_valid;
    logic          cplx_mode;
    logic          fft_busy;
    logic          fft_stall;
    logic [2*SW-1:0] fft_data;
    logic [IW-1:0] fft_idx;
    logic          fft_load;
    logic          fft_start;
    logic [1:0]    bank_full;
    logic          frame_drop;
    logic          overflow;

    int compared   = 0;
    int mismatched = 0;

    fft_pingpong_loader #(
        .N_POINTS (N),
        .SAMPLE_W (SW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .cplx_mode   (cplx_mode),
        .fft_busy    (fft_busy),
        .fft_stall   (fft_stall),
        .fft_data    (fft_data),
        .fft_idx     (fft_idx),
        .fft_load    (fft_load),
        .fft_start   (fft_start),
        .bank_full   (bank_full),
        .frame_drop  (frame_drop),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Real frame: point i = base+i in the upper half, junk in the unused lower half.
    function automatic logic [FW-1:0] mk_real(input logic [15:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f = (f << SW) | FW'(base + 16'(i));
        for (int i = 0; i < N; i++) f = (f << SW) | FW'(16'hDEAD ^ 16'(i));
        return f;
    endfunction

    // Complex frame: point i = {re_base+i, im_base+i}.
    function automatic logic [FW-1:0] mk_cplx(input logic [15:0] re_base, input logic [15:0] im_base);
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f = (f << (2 * SW)) | FW'({re_base + 16'(i), im_base + 16'(i)});
        return f;
    endfunction

    // Follows one full load window starting in the first LOAD cycle, then the
    // START cycle, and returns in the following IDLE cycle. Optionally stalls
    // at one index and injects a frame on a chosen window cycle (64+stalls = START).
    task automatic check_load(input logic [15:0] rb, input logic [15:0] ib, input logic cx,
                              input int stall_at, input int stall_len,
                              input int inj_at, input logic [FW-1:0] inj_f, input logic inj_cx);
        int i = 0;
        int w = 0;
        int sc = 0;
        logic stalled;
        logic [31:0] exp_data;
        while (i < N) begin
            tick();
            if (w == inj_at) begin
                frame_in = inj_f; cplx_mode = inj_cx; frame_valid = 1'b1;
            end else begin
                frame_valid = 1'b0;
            end
            stalled = (i == stall_at) && (sc < stall_len);
            fft_stall = stalled;
            if (stalled) sc++;
            settle();
            if (stalled) begin
                check("stall_load", 64'(fft_load), 64'(0));
                check("stall_idx", 64'(fft_idx), 64'(i));
            end else begin
                exp_data = cx ? {rb + 16'(i), ib + 16'(i)} : {rb + 16'(i), 16'h0000};
                check("load", 64'(fft_load), 64'(1));
                check("idx", 64'(fft_idx), 64'(i));
                check("data", 64'(fft_data), 64'(exp_data));
                check("no_start", 64'(fft_start), 64'(0));
                i++;
            end
            w++;
        end
        tick();
        fft_stall = 1'b0;
        if (w == inj_at) begin
            frame_in = inj_f; cplx_mode = inj_cx; frame_valid = 1'b1;
        end else begin
            frame_valid = 1'b0;
        end
        settle();
        check("window_len", 64'(w), 64'(N + stall_len));
        check("start", 64'(fft_start), 64'(1));
        check("start_load", 64'(fft_load), 64'(0));
        tick();
        frame_valid = 1'b0;
        settle();
        check("start_pulse_end", 64'(fft_start), 64'(0));
        check("idle_load", 64'(fft_load), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_in = '0; frame_valid = 1'b0; cplx_mode = 1'b0;
        fft_busy = 1'b0; fft_stall = 1'b0;

        // ---- Reset state ----
        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_load", 64'(fft_load), 64'(0));
        check("rst_start", 64'(fft_start), 64'(0));
        check("rst_idx", 64'(fft_idx), 64'(0));
        check("rst_bank_full", 64'(bank_full), 64'(2'b00));
        check("rst_drop", 64'(frame_drop), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));

        // ---- Real frame: first load at k+2, start at k+66 ----
        tick();
        frame_in = mk_real(16'h0100); cplx_mode = 1'b0; frame_valid = 1'b1;   // cycle k
        tick();
        frame_valid = 1'b0;                                                   // k+1
        settle();
        check("t1_full", 64'(bank_full), 64'(2'b01));
        check("t1_no_load_yet", 64'(fft_load), 64'(0));
        check_load(16'h0100, 16'h0000, 1'b0, -1, 0, -1, '0, 1'b0);
        check("t1_empty", 64'(bank_full), 64'(2'b00));
        check("t1_idx_hold", 64'(fft_idx), 64'(N - 1));

        // ---- Complex frame, real frame arriving mid-load into the other bank ----
        tick();
        frame_in = mk_cplx(16'hA000, 16'h5000); cplx_mode = 1'b1; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        settle();
        check("t2_full", 64'(bank_full), 64'(2'b10));
        check_load(16'hA000, 16'h5000, 1'b1, -1, 0, 5, mk_real(16'h0600), 1'b0);
        check("t2_next_full", 64'(bank_full), 64'(2'b01));
        check_load(16'h0600, 16'h0000, 1'b0, -1, 0, -1, '0, 1'b0);
        check("t2_empty", 64'(bank_full), 64'(2'b00));

        // ---- Three frames while busy: third dropped, first two delivered in order ----
        fft_busy = 1'b1;
        tick();
        frame_in = mk_real(16'h1000); cplx_mode = 1'b0; frame_valid = 1'b1;
        tick();
        frame_in = mk_cplx(16'h2000, 16'h3000); cplx_mode = 1'b1; frame_valid = 1'b1;
        settle();
        check("t3_one_full", 64'(bank_full), 64'(2'b10));
        tick();
        frame_in = mk_real(16'h4000); cplx_mode = 1'b0; frame_valid = 1'b1;
        settle();
        check("t3_both_full", 64'(bank_full), 64'(2'b11));
        check("t3_no_drop_yet", 64'(frame_drop), 64'(0));
        tick();
        frame_valid = 1'b0;
        settle();
        check("t3_drop", 64'(frame_drop), 64'(1));
        check("t3_overflow", 64'(overflow), 64'(1));
        check("t3_busy_no_load", 64'(fft_load), 64'(0));
        check("t3_still_full", 64'(bank_full), 64'(2'b11));
        tick();
        fft_busy = 1'b0;
        settle();
        check("t3_drop_pulse_end", 64'(frame_drop), 64'(0));
        check("t3_overflow_sticky", 64'(overflow), 64'(1));
        check("t3_idle", 64'(fft_load), 64'(0));
        check_load(16'h1000, 16'h0000, 1'b0, -1, 0, -1, '0, 1'b0);
        check("t3_second_pending", 64'(bank_full), 64'(2'b01));
        check_load(16'h2000, 16'h3000, 1'b1, -1, 0, -1, '0, 1'b0);
        check("t3_empty", 64'(bank_full), 64'(2'b00));
        for (int c = 0; c < 4; c++) begin
            tick();
            settle();
            check("t3_no_third", 64'(fft_load), 64'(0));
        end

        // ---- Stall for 3 cycles at idx 10: window is 67 cycles ----
        tick();
        frame_in = mk_real(16'h7000); cplx_mode = 1'b0; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        check_load(16'h7000, 16'h0000, 1'b0, 10, 3, -1, '0, 1'b0);

        // ---- Frame on a START cycle with both banks full is accepted ----
        tick();
        frame_in = mk_real(16'h0A00); cplx_mode = 1'b0; frame_valid = 1'b1;   // X
        tick();
        frame_in = mk_cplx(16'h0B00, 16'h0C00); cplx_mode = 1'b1; frame_valid = 1'b1;  // Y
        settle();
        check("t5_first_full", 64'(bank_full), 64'(2'b01));
        check_load(16'h0A00, 16'h0000, 1'b0, -1, 0, N, mk_real(16'h0D00), 1'b0);  // Z on START
        check("t5_full_after_refill", 64'(bank_full), 64'(2'b11));
        check("t5_no_drop", 64'(frame_drop), 64'(0));
        check_load(16'h0B00, 16'h0C00, 1'b1, -1, 0, -1, '0, 1'b0);
        check_load(16'h0D00, 16'h0000, 1'b0, -1, 0, -1, '0, 1'b0);
        check("t5_empty", 64'(bank_full), 64'(2'b00));

        // ---- Reset in the middle of a load at idx 30, second bank also full ----
        tick();
        frame_in = mk_real(16'h3300); cplx_mode = 1'b0; frame_valid = 1'b1;
        tick();
        frame_in = mk_real(16'h4400); cplx_mode = 1'b0; frame_valid = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            tick();
            frame_valid = 1'b0;
            settle();
            check("t6_idx", 64'(fft_idx), 64'(i));
            check("t6_data", 64'(fft_data), 64'({16'h3300 + 16'(i), 16'h0000}));
            if (i == 30) reset = 1'b1;
        end
        tick();
        reset = 1'b0;
        settle();
        check("t6_load_abort", 64'(fft_load), 64'(0));
        check("t6_banks_empty", 64'(bank_full), 64'(2'b00));
        check("t6_overflow_clr", 64'(overflow), 64'(0));
        check("t6_no_start", 64'(fft_start), 64'(0));
        check("t6_idx_rst", 64'(fft_idx), 64'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            settle();
            check("t6_quiet_start", 64'(fft_start), 64'(0));
            check("t6_quiet_load", 64'(fft_load), 64'(0));
        end
        tick();
        frame_in = mk_cplx(16'h9000, 16'h8000); cplx_mode = 1'b1; frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
        settle();
        check("t6_fresh_full", 64'(bank_full), 64'(2'b01));
        check_load(16'h9000, 16'h8000, 1'b1, -1, 0, -1, '0, 1'b0);
        check("t6_fresh_empty", 64'(bank_full), 64'(2'b00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
